imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: word-address width of the instruction memory write port (depth 2^ADDR_WIDTH words).
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a program load.
REQ-005 word_count  input  ADDR_WIDTH+1  number of 32-bit words to load; sampled only when start is accepted.
REQ-006 rx_data  input  8  incoming program byte.
REQ-007 rx_valid  input  1  rx_data holds a valid byte.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both 1.
REQ-009 mem_we  output  1  instruction memory write strobe.
REQ-010 mem_addr  output  ADDR_WIDTH  instruction memory word address.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the processor PC/fetch frozen while 1.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  one-cycle pulse at load completion.
REQ-015 error  output  1  checksum mismatch flag (see Configuration).

Function
REQ-016 The loader SHALL implement states IDLE, LOAD, WRITE, CHECK (configuration-dependent) and DONE.
REQ-017 IDLE: rx_ready=0, busy=0, mem_we=0; start with word_count≠0 SHALL go to LOAD, latch count, clear byte index and address, set cpu_hold=1, clear error.
REQ-018 start with word_count=0 in IDLE SHALL assert done for one cycle, write nothing, and leave cpu_hold unchanged.
REQ-019 word_count greater than 2^ADDR_WIDTH SHALL be treated as 2^ADDR_WIDTH; mem_addr SHALL never wrap within one load.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 LOAD: rx_ready=1, busy=1; each accepted byte fills the word big-endian (first byte to bits 31:24, fourth to 7:0); after the fourth accepted byte the state SHALL go to WRITE.
REQ-022 rx_valid low in LOAD SHALL stall indefinitely with no state change (no timeout).
REQ-023 WRITE: exactly one cycle with mem_we=1, rx_ready=0, mem_addr=current word index, mem_wdata=assembled word; mem_addr SHALL increment after the write.
REQ-024 After WRITE, the state SHALL return to LOAD if words remain, otherwise go to CHECK (macro defined) or DONE.
REQ-025 Throughput: back-to-back bytes SHALL yield one write every 5 cycles; mem_we asserts in the cycle after the fourth byte handshake.
REQ-026 DONE: done=1 for exactly one cycle, busy=0, cpu_hold cleared at the end of that cycle, then IDLE.
REQ-027 mem_we SHALL be 0 in every state except WRITE; mem_wdata and mem_addr are don't-care when mem_we=0.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1.
REQ-029 Reset mid-load SHALL discard any partial word without issuing a write; cpu_hold stays 1 until a later load completes.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN: when defined, the loader SHALL keep an 8-bit modulo-256 sum of all data bytes and enter CHECK after the last WRITE.
REQ-031 CHECK (macro defined): rx_ready=1, accept one checksum byte; error SHALL be set if (sum + checksum byte) mod 256 ≠ 0, then go to DONE; error holds until the next accepted start or reset.
REQ-032 Without the macro: no CHECK state, no sum register, error tied to 0, last WRITE goes directly to DONE.

Verification
REQ-033 Reset then idle -> cpu_hold=1, busy=0, rx_ready=0, mem_we=0.
REQ-034 start, word_count=2, bytes 20 08 00 05 8C 09 00 04 back-to-back -> writes addr0=0x20080005 (cycle after 4th byte), addr1=0x8C090004, done pulse, cpu_hold falls.
REQ-035 start, word_count=1, rx_valid toggling every other cycle with bytes 00 00 00 01 -> single write addr0=0x00000001, no write before 4th byte.
REQ-036 rst_n low after 2 bytes of word 1 in a 3-word load -> no write, all outputs at reset values; new load of 1 word then writes addr0.
REQ-037 start during LOAD and start with word_count=0 in IDLE -> first ignored; second gives done pulse with no mem_we.
REQ-038 Macro defined, 1 word 01 02 03 04 then checksum F6 -> error=0; checksum F5 -> error=1 held until next start.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: assembles big-endian 32-bit words from a byte stream and writes them while holding the CPU.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte and the error flag.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  // Byte handshake: a byte transfers on a rising edge where rx_valid and rx_ready are both 1.
  // rx_ready is 1 only in LOAD (and CHECK), and the sender may hold rx_valid low for any length of time.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0]   MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   WORDS_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t              state;
  logic [ADDR_WIDTH:0] words_left;
  logic [1:0]          byte_idx;
  logic [23:0]         shift_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] check_total;
  assign check_total = sum_q + rx_data;
`else
  assign error = 1'b0;
`endif

  assign dbg_state = state;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      words_left <= '0;
      byte_idx   <= '0;
      shift_q    <= '0;
      rx_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      error      <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              state      <= S_LOAD;
              words_left <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
              byte_idx   <= '0;
              mem_addr   <= '0;
              cpu_hold   <= 1'b1;
              rx_ready   <= 1'b1;
              busy       <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum_q      <= '0;
              error      <= 1'b0;
`endif
            end else begin
              // Empty load: report completion only, leaving cpu_hold as it was.
              done <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (rx_valid) begin
            shift_q  <= {shift_q[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= sum_q + rx_data;
`endif
            if (byte_idx == 2'd3) begin
              mem_wdata <= {shift_q, rx_data};
              mem_we    <= 1'b1;
              rx_ready  <= 1'b0;
              state     <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          words_left <= words_left - WORDS_ONE;
          if (words_left != WORDS_ONE) begin
            mem_addr <= mem_addr + ADDR_ONE;
            rx_ready <= 1'b1;
            state    <= S_LOAD;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            rx_ready <= 1'b1;
            state    <= S_CHECK;
`else
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
`endif
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (rx_valid) begin
            error    <= (check_total != 8'h00);
            rx_ready <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          rx_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_WIDTH=2 so the word-count clamp is reachable).
// Build with +define+IMEM_LOADER_CHECKSUM_EN to also exercise the checksum path.
module tb_imem_loader;
  localparam int AW = 2;

  logic          clock;
  logic          rst_n;
  logic          start;
  logic [AW:0]   word_count;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int cyc      = 0;
  logic [AW+31:0] exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .word_count(word_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {30'd0, mem_addr, mem_wdata}, 64'hDEAD);
      end else begin
        check("write", {30'd0, mem_addr, mem_wdata}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [AW:0] n);
    start      = 1'b1;
    word_count = n;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent;
    sent     = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !sent; i++) begin
      if (rx_ready === 1'b1) sent = 1'b1;
      tick();
    end
    if (!sent) check("rx_ready_timeout", 64'd0, 64'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  // called right after the last data byte; ends one cycle after the DONE cycle
  task automatic end_load(input string tag, input logic [7:0] cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    if (cs == 8'hFF) $display("note: unused checksum %0h", cs);
    tick();
`endif
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_hold_in_done"}, cpu_hold, 1'b1);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_hold_released"}, cpu_hold, 1'b0);
  endtask

  initial begin
    int t0;
    int w0;
    rst_n = 1'b0; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // reset then idle
    check("rst_hold", cpu_hold, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", rx_ready, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_addr", mem_addr, 2'd0);

    // two words back-to-back
    exp_q.push_back({2'd0, 32'h20080005});
    exp_q.push_back({2'd1, 32'h8C090004});
    do_start(3'd2);
    check("bb_busy", busy, 1'b1);
    check("bb_ready", rx_ready, 1'b1);
    send_word(32'h20080005);
    check("bb_we0", mem_we, 1'b1);
    check("bb_wdata0", mem_wdata, 32'h20080005);
    t0 = cyc;
    send_word(32'h8C090004);
    check("bb_we1", mem_we, 1'b1);
    check("bb_addr1", mem_addr, 2'd1);
    check("bb_period", cyc - t0, 5);
    end_load("bb", 8'h3A);

    // one word with rx_valid toggling
    exp_q.push_back({2'd0, 32'h00000001});
    do_start(3'd1);
    w0 = n_writes;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b0;
      tick();
      check("tg_stall_ready", rx_ready, 1'b1);
      if (i == 3) check("tg_no_early_write", n_writes - w0, 0);
      send_byte((i == 3) ? 8'h01 : 8'h00);
    end
    check("tg_we", mem_we, 1'b1);
    end_load("tg", 8'hFF);

    // reset mid-load discards the partial word
    do_start(3'd3);
    send_byte(8'h20);
    send_byte(8'h08);
    #2 rst_n = 1'b0;
    #1;
    check("mid_ready", rx_ready, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_hold", cpu_hold, 1'b1);
    check("mid_wdata", mem_wdata, 32'h0);
    check("mid_addr", mem_addr, 2'd0);
    check("mid_state", dbg_state, 3'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_hold_after", cpu_hold, 1'b1);
    exp_q.push_back({2'd0, 32'hAABBCCDD});
    do_start(3'd1);
    send_word(32'hAABBCCDD);
    end_load("mid", 8'hF2);

    // start during LOAD is ignored; zero-count start gives a bare done pulse
    exp_q.push_back({2'd0, 32'h01020304});
    exp_q.push_back({2'd1, 32'h05060708});
    do_start(3'd2);
    send_byte(8'h01);
    do_start(3'd5);
    check("ign_busy", busy, 1'b1);
    check("ign_ready", rx_ready, 1'b1);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_word(32'h05060708);
    end_load("ign", 8'hDC);
    w0 = n_writes;
    do_start(3'd0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_hold", cpu_hold, 1'b0);
    tick();
    check("zero_done_pulse", done, 1'b0);
    check("zero_no_write", n_writes - w0, 0);

    // word_count above depth is clamped to 4 words
    exp_q.push_back({2'd0, 32'h00010203});
    exp_q.push_back({2'd1, 32'h04050607});
    exp_q.push_back({2'd2, 32'h08090A0B});
    exp_q.push_back({2'd3, 32'h0C0D0E0F});
    w0 = n_writes;
    do_start(3'd7);
    send_word(32'h00010203);
    send_word(32'h04050607);
    send_word(32'h08090A0B);
    send_word(32'h0C0D0E0F);
    check("sat_addr3", mem_addr, 2'd3);
    end_load("sat", 8'h88);
    check("sat_writes", n_writes - w0, 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_q.push_back({2'd0, 32'h01020304});
    do_start(3'd1);
    send_word(32'h01020304);
    end_load("cs_good", 8'hF6);
    check("cs_good_err", error, 1'b0);
    exp_q.push_back({2'd0, 32'h01020304});
    do_start(3'd1);
    send_word(32'h01020304);
    end_load("cs_bad", 8'hF5);
    check("cs_bad_err", error, 1'b1);
    repeat (3) tick();
    check("cs_err_held", error, 1'b1);
    exp_q.push_back({2'd0, 32'h01020304});
    do_start(3'd1);
    check("cs_err_cleared", error, 1'b0);
    send_word(32'h01020304);
    end_load("cs_again", 8'hF6);
`endif

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
